// File: rtl/regfile_write_sched_pkg.sv
// Shared CPU definitions for the register-file write scheduler.
//   REG_ZERO           - hard-wired zero register index
//   reg_idx_t          - 5-bit architectural register index
//   sched_state_t      - write-port arbitration FSM states
//   STARVE_MAX_DEFAULT - default forced-grant bound for the long-latency unit
package regfile_write_sched_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DEFER = 2'd1,
        ST_FORCE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/regfile_write_sched_if.sv
// Bundle of every non-clock signal of the register-file write scheduler.
//   master : the CPU side (pipeline writeback, decode, long-latency unit)
//   slave  : the scheduler itself
//
// Handshake semantics:
//   issue_valid/issue_ack : an issue is accepted in exactly the cycle where
//     both are high; decode keeps issue_valid/issue_reg stable and retries
//     while issue_ack is low.
//   lu_req/lu_gnt : a long-latency result is consumed in exactly the cycle
//     where both are high; the unit must hold lu_req/lu_reg/lu_data stable
//     until it sees lu_gnt.
//   wb_valid has no handshake; the pipeline only freezes when wb_hold is high.
interface regfile_write_sched_if
    import regfile_write_sched_pkg::*;
#(
    parameter int DW = 32
);
    logic          wb_valid;
    reg_idx_t      wb_reg;
    logic [DW-1:0] wb_data;
    logic          wb_hold;
    logic          issue_valid;
    reg_idx_t      issue_reg;
    logic          issue_ack;
    logic          lu_req;
    reg_idx_t      lu_reg;
    logic [DW-1:0] lu_data;
    logic          lu_gnt;
    reg_idx_t      rs;
    reg_idx_t      rt;
    logic          hazard;
    logic          rf_we;
    reg_idx_t      rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   pending;
    sched_state_t  state;     // debug view of the arbitration FSM

    modport master (
        output wb_valid, wb_reg, wb_data,
        output issue_valid, issue_reg,
        output lu_req, lu_reg, lu_data,
        output rs, rt,
        input  wb_hold, issue_ack, lu_gnt, hazard,
        input  rf_we, rf_waddr, rf_wdata, pending, state
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  issue_valid, issue_reg,
        input  lu_req, lu_reg, lu_data,
        input  rs, rt,
        output wb_hold, issue_ack, lu_gnt, hazard,
        output rf_we, rf_waddr, rf_wdata, pending, state
    );
endinterface

// File: rtl/regfile_write_sched_scoreboard.sv
// Pending-destination scoreboard for ops in flight in the long-latency unit.
//   clk, rst     - clock, asynchronous active-high reset
//   clr_i        - a long-latency result is granted this cycle
//   clr_reg_i    - destination of that result (bit cleared at the edge)
//   set_valid_i  - decode requests an issue this cycle
//   set_reg_i    - destination of the issued op
//   set_ack_o    - issue accepted (destination not already pending)
//   rs_i, rt_i   - decode source registers
//   hazard_o     - a source register is still pending
//   pending_o    - registered pending vector
module regfile_write_sched_scoreboard
    import regfile_write_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  reg_idx_t    clr_reg_i,
    input  logic        set_valid_i,
    input  reg_idx_t    set_reg_i,
    output logic        set_ack_o,
    input  reg_idx_t    rs_i,
    input  reg_idx_t    rt_i,
    output logic        hazard_o,
    output logic [31:0] pending_o
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;

    // The ack looks at the pre-edge vector, so an issue to the register being
    // granted in the same cycle is refused and decode retries next cycle.
    assign set_ack_o = set_valid_i & ~pending_q[set_reg_i];

    assign hazard_o = ((rs_i != REG_ZERO) & pending_q[rs_i]) |
                      ((rt_i != REG_ZERO) & pending_q[rt_i]);

    always_comb begin
        pending_d = pending_q;
        if (clr_i) begin
            pending_d[clr_reg_i] = 1'b0;
        end
        // Register 0 is never tracked: writes to it are discarded anyway.
        if (set_ack_o && (set_reg_i != REG_ZERO)) begin
            pending_d[set_reg_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_write_sched.sv
// Single write-port scheduler in front of the CPU register file.
// Writeback has priority; the long-latency unit is granted when writeback is
// idle, and is force-granted (with writeback held) after STARVE_MAX refusals.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - regfile_write_sched_if slave: writeback, issue, long-latency
//              result, decode sources, hazard, registered rf write port,
//              pending vector and FSM state
module regfile_write_sched
    import regfile_write_sched_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int DW         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_write_sched_if.slave bus
);

    localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);

    sched_state_t  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          hold_q, hold_d;
    logic          rf_we_q, rf_we_d;
    reg_idx_t      rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          sel_wb;
    logic          sel_lu;
    logic [31:0]   pending;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hold_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // Next-state logic; cnt counts consecutive refusals of a waiting lu_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.lu_req && bus.wb_valid) begin
                    cnt_d   = 4'd1;
                    state_d = ST_DEFER;
                end
            end
            ST_DEFER: begin
                // A dropped lu_req here is unit misuse; recover to IDLE.
                if (!bus.lu_req || !bus.wb_valid) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_FORCE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        // Reaching the bound freezes writeback for the following cycle, which
        // is the cycle spent in FORCE granting the long-latency unit.
        if ((state_d == ST_DEFER) && (cnt_d >= STARVE_CNT)) begin
            state_d = ST_FORCE;
            hold_d  = 1'b1;
        end
    end

    // Output logic: write-port selection and registered rf write staging.
    always_comb begin
        sel_wb = 1'b0;
        sel_lu = 1'b0;
        case (state_q)
            ST_IDLE, ST_DEFER: begin
                sel_wb = bus.wb_valid;
                sel_lu = bus.lu_req & ~bus.wb_valid;
            end
            ST_FORCE: begin
                sel_lu = bus.lu_req;
            end
            default: begin
                sel_wb = 1'b0;
                sel_lu = 1'b0;
            end
        endcase

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (sel_lu) begin
            rf_we_d    = (bus.lu_reg != REG_ZERO);
            rf_waddr_d = bus.lu_reg;
            rf_wdata_d = bus.lu_data;
        end else if (sel_wb) begin
            rf_we_d    = (bus.wb_reg != REG_ZERO);
            rf_waddr_d = bus.wb_reg;
            rf_wdata_d = bus.wb_data;
        end
    end

    regfile_write_sched_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (sel_lu),
        .clr_reg_i   (bus.lu_reg),
        .set_valid_i (bus.issue_valid),
        .set_reg_i   (bus.issue_reg),
        .set_ack_o   (bus.issue_ack),
        .rs_i        (bus.rs),
        .rt_i        (bus.rt),
        .hazard_o    (bus.hazard),
        .pending_o   (pending)
    );

    assign bus.lu_gnt   = sel_lu;
    assign bus.wb_hold  = hold_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.pending  = pending;
    assign bus.state    = state_q;

    // Writeback to a register still owed by the long-latency unit is a
    // pipeline WAW bug: the late result would overwrite the newer value.
    waw_to_pending_reg: assert property (@(posedge clk) disable iff (rst)
        !(bus.wb_valid && (bus.wb_reg != REG_ZERO) && pending[bus.wb_reg]));

endmodule

// File: tb/tb_regfile_write_sched.sv
module tb_regfile_write_sched;
  import regfile_write_sched_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [36:0] exp_q[$];   // expected rf writes {addr, data}

  regfile_write_sched_if #(.DW(32)) bus ();

  regfile_write_sched #(.STARVE_MAX(4), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic set_idle();
    bus.wb_valid    = 1'b0;
    bus.wb_reg      = '0;
    bus.wb_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_reg   = '0;
    bus.lu_req      = 1'b0;
    bus.lu_reg      = '0;
    bus.lu_data     = '0;
    bus.rs          = '0;
    bus.rt          = '0;
  endtask

  // Inputs change at the falling edge; comb outputs are checked 1 ns later,
  // registered outputs then show the selection made at the previous rise.
  task automatic next_cycle();
    @(negedge clk);
    set_idle();
  endtask

  task automatic drive_wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_reg   = r;
    bus.wb_data  = d;
  endtask

  task automatic drive_lu(input logic [4:0] r, input logic [31:0] d);
    bus.lu_req  = 1'b1;
    bus.lu_reg  = r;
    bus.lu_data = d;
  endtask

  task automatic drive_issue(input logic [4:0] r);
    bus.issue_valid = 1'b1;
    bus.issue_reg   = r;
  endtask

  // scoreboard: every rf write must match the next expected entry
  always @(negedge clk) begin
    if (!rst && bus.rf_we) begin
      if (exp_q.size() == 0) begin
        check("rf_unexpected_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, 64'd0);
      end else begin
        check("rf_write", {27'd0, bus.rf_waddr, bus.rf_wdata}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  logic [5:0]   sv_gnt  = 6'b010000;
  logic [5:0]   sv_hold = 6'b010000;
  sched_state_t sv_st[6] = '{ST_IDLE, ST_DEFER, ST_DEFER, ST_DEFER, ST_FORCE, ST_IDLE};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    set_idle();
    #2;
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_waddr", bus.rf_waddr, 0);
    check("rst_rf_wdata", bus.rf_wdata, 0);
    check("rst_wb_hold", bus.wb_hold, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_state", bus.state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // basic writeback
    next_cycle(); drive_wb(5'd8, 32'h1234); exp_q.push_back({5'd8, 32'h1234});
    #1 check("wb_no_gnt", bus.lu_gnt, 0);
    next_cycle(); drive_wb(5'd0, 32'h5555);
    #1 check("wb8_we", bus.rf_we, 1);
    check("wb8_addr", bus.rf_waddr, 8);
    check("wb8_data", bus.rf_wdata, 32'h1234);
    next_cycle();
    #1 check("wb0_we", bus.rf_we, 0);

    // scoreboard round trip on reg 5
    next_cycle(); drive_issue(5'd5);
    #1 check("iss5_ack", bus.issue_ack, 1);
    next_cycle(); bus.rs = 5'd5;
    #1 check("iss5_pending", bus.pending, 32'h0000_0020);
    check("iss5_hazard", bus.hazard, 1);
    next_cycle(); bus.rs = 5'd5; drive_lu(5'd5, 32'hCAFE); exp_q.push_back({5'd5, 32'hCAFE});
    #1 check("lu5_gnt", bus.lu_gnt, 1);
    check("lu5_hazard_before", bus.hazard, 1);
    next_cycle(); bus.rs = 5'd5;
    #1 check("lu5_pending", bus.pending, 0);
    check("lu5_hazard_after", bus.hazard, 0);
    check("lu5_addr", bus.rf_waddr, 5);
    check("lu5_data", bus.rf_wdata, 32'hCAFE);

    // repeat issue on reg 7
    next_cycle(); drive_issue(5'd7);
    #1 check("iss7_first_ack", bus.issue_ack, 1);
    next_cycle(); drive_issue(5'd7); bus.rt = 5'd7;
    #1 check("iss7_second_ack", bus.issue_ack, 0);
    check("iss7_rt_hazard", bus.hazard, 1);
    next_cycle();
    #1 check("iss7_pending", bus.pending, 32'h0000_0080);
    drive_lu(5'd7, 32'h77); exp_q.push_back({5'd7, 32'h77});
    #1 check("lu7_gnt", bus.lu_gnt, 1);
    next_cycle();
    #1 check("lu7_pending", bus.pending, 0);

    // issue to reg 0 is always acked and never tracked
    next_cycle(); drive_issue(5'd0);
    #1 check("iss0_ack", bus.issue_ack, 1);
    next_cycle();
    #1 check("iss0_pending", bus.pending, 0);

    // starvation: 4 refusals, one forced grant, then writeback resumes
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive_wb(5'(10 + (i < 4 ? i : 4)), 32'h100 + 32'(i < 4 ? i : 4));
      if (i <= 4) drive_lu(5'd3, 32'hBEEF);
      if (i < 4)       exp_q.push_back({5'(10 + i), 32'h100 + 32'(i)});
      else if (i == 4) exp_q.push_back({5'd3, 32'hBEEF});
      else             exp_q.push_back({5'd14, 32'h104});
      #1;
      check($sformatf("starve_gnt_%0d", i), bus.lu_gnt, sv_gnt[i]);
      check($sformatf("starve_hold_%0d", i), bus.wb_hold, sv_hold[i]);
      check($sformatf("starve_state_%0d", i), bus.state, sv_st[i]);
    end
    next_cycle();
    #1 check("resume_addr", bus.rf_waddr, 14);
    check("resume_hold", bus.wb_hold, 0);

    // same-cycle grant and issue of reg 9
    next_cycle(); drive_issue(5'd9);
    #1 check("iss9_ack", bus.issue_ack, 1);
    next_cycle(); drive_issue(5'd9); drive_lu(5'd9, 32'h99); exp_q.push_back({5'd9, 32'h99});
    #1 check("same9_gnt", bus.lu_gnt, 1);
    check("same9_ack", bus.issue_ack, 0);
    next_cycle();
    #1 check("same9_pending", bus.pending, 0);

    // async reset in the middle of FORCE
    next_cycle(); drive_issue(5'd12);
    #1 check("iss12_ack", bus.issue_ack, 1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive_wb(5'(20 + i), 32'h200 + 32'(i));
      drive_lu(5'd12, 32'hDEAD);
      if (i < 4) exp_q.push_back({5'(20 + i), 32'h200 + 32'(i)});
    end
    #1 check("force_state", bus.state, ST_FORCE);
    check("force_hold", bus.wb_hold, 1);
    check("force_pending", bus.pending, 32'h0000_1000);
    #2 rst = 1'b1;
    #1 check("arst_rf_we", bus.rf_we, 0);
    check("arst_rf_waddr", bus.rf_waddr, 0);
    check("arst_rf_wdata", bus.rf_wdata, 0);
    check("arst_hold", bus.wb_hold, 0);
    check("arst_pending", bus.pending, 0);
    check("arst_state", bus.state, ST_IDLE);
    check("arst_gnt", bus.lu_gnt, 0);
    next_cycle();
    rst = 1'b0;
    #1 check("post_rst_state", bus.state, ST_IDLE);
    check("post_rst_we", bus.rf_we, 0);
    next_cycle(); drive_wb(5'd8, 32'hA5); exp_q.push_back({5'd8, 32'hA5});
    next_cycle();
    #1 check("post_rst_write", bus.rf_we, 1);
    next_cycle();
    #1 check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_sched.md
Name: regfile_write_sched

Overview:
- Single-write-port scheduler and scoreboard in front of the CPU register file.
- Shares the one write port between two requesters:
  - the in-order pipeline writeback stage (high priority, no handshake);
  - a long-latency unit (multi-cycle mul/div/load), which uses a req/gnt handshake.
- Tracks destinations issued to the long-latency unit and produces a read-hazard stall for decode.
- Guarantees the long-latency unit forward progress by holding writeback after a bounded wait.

Parameters:
- STARVE_MAX, 4, number of consecutive cycles the long-latency request may be refused before the scheduler forces a grant (legal range 1..15).
- DW, 32, write data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- wb_valid  in  1  pipeline writeback wants the write port this cycle.
- wb_reg  in  5  pipeline destination register.
- wb_data  in  DW  pipeline write data.
- wb_hold  out  1  pipeline must freeze its writeback stage this cycle; registered.
- issue_valid  in  1  decode issues an op to the long-latency unit.
- issue_reg  in  5  destination of the issued op.
- issue_ack  out  1  combinational; issue accepted.
- lu_req  in  1  long-latency unit has a result.
- lu_reg  in  5  result destination.
- lu_data  in  DW  result data.
- lu_gnt  out  1  combinational; result consumed this cycle.
- rs, rt  in  5 each  decode source registers.
- hazard  out  1  combinational; decode must stall.
- rf_we  out  1  register-file write enable; registered.
- rf_waddr  out  5  register-file write address; registered.
- rf_wdata  out  DW  register-file write data; registered.
- pending  out  32  scoreboard vector; registered.

Behaviour:
- Reset (async, immediate):
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_hold=0, pending=0.
  - Starve counter=0, FSM=IDLE.
- Register-file latch:
  - The register file writes on the falling clock edge.
  - rf_* are registered on the rising edge, so a write selected in cycle N lands at the falling edge of cycle N+1.
  - Fixed latency: 1 cycle from selection to rf_we.
- Register 0:
  - Any selected write with destination 0 produces rf_we=0.
  - The scoreboard bit is still cleared and lu_gnt is still given.
  - pending[0] is never set; issue to reg 0 is always acked.
- hazard = (rs!=0 & pending[rs]) | (rt!=0 & pending[rt]).
- issue_ack = issue_valid & ~pending[issue_reg].
  - Ack sets pending[issue_reg] at the next edge.
  - An issue to an already-pending register is refused (decode retries).
- FSM states IDLE, DEFER, FORCE:
  - IDLE:
    - lu_req & ~wb_valid -> lu_gnt=1, select lu, stay IDLE.
    - lu_req & wb_valid -> select wb, lu_gnt=0, counter=1, go DEFER.
    - Otherwise select wb if valid.
  - DEFER:
    - ~wb_valid -> lu_gnt=1, counter=0, go IDLE.
    - wb_valid -> select wb, counter++.
    - When counter reaches STARVE_MAX, assert wb_hold (registered) and go FORCE.
  - FORCE:
    - wb_hold=1; lu_gnt=1, select lu regardless of wb_valid.
    - Next cycle: wb_hold=0, counter=0, go IDLE.
  - lu_req deasserting while in DEFER returns to IDLE, counter=0. This is protocol misuse; the bench flags it.
- Scoreboard update on the same edge, in order:
  1. clear pending[lu_reg] on lu grant;
  2. set pending[issue_reg] on issue_ack.
  - Issue to the same reg as a same-cycle grant is refused, because its pending bit was still set when checked.
- WAW rule: wb_valid with wb_reg pending is a pipeline bug.
  - The write proceeds and pending is not cleared.
  - An assertion fires in simulation.
- Reset mid-FORCE or mid-DEFER: the in-flight lu result is lost and pending is cleared; the unit must also be reset by rst.

Decomposition:
- Shared CPU package holds:
  - REG_ZERO=5'd0;
  - the register-index typedef (5 bits);
  - the FSM state enum (IDLE/DEFER/FORCE);
  - STARVE_MAX default.
- One natural sub-module: regfile_scoreboard. It holds the 32-bit pending vector, set/clear ports, and the combinational hazard/ack lookups.
- The top-level module holds the FSM, counter and write-port mux.

Test Plan:
- Basic writes:
  - Drive wb_valid=1, wb_reg=8, wb_data=0x1234 for one cycle -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x1234.
  - wb_reg=0 -> rf_we stays 0.
- Scoreboard round trip:
  - issue_reg=5 acked -> pending[5]=1; rs=5 gives hazard=1.
  - lu_req reg5 data 0xCAFE with idle wb -> lu_gnt=1 same cycle, rf write 5/0xCAFE next cycle, pending[5]=0, hazard=0.
- Repeat issue: issue reg 7 twice with no grant between -> second issue_ack=0, pending unchanged.
- Starvation, STARVE_MAX=4:
  - Hold wb_valid=1 continuously while lu_req=1.
  - lu_gnt stays 0 for 4 cycles, then wb_hold=1 and lu_gnt=1 for exactly one cycle.
  - wb_hold drops; pipeline writes resume.
- Same-cycle grant/issue of reg 9 (pending) -> grant clears bit, issue_ack=0, pending[9]=0 after edge.
- Async reset asserted mid-FORCE -> all outputs 0 immediately, without waiting for a clock edge; FSM=IDLE after release.
